// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack processor: opcodes, default program image
// and the fetch FSM state encoding.
package stack_cpu_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_NOP1    = 8'h01;
  localparam logic [7:0] OP_LED_OFF = 8'h02;
  localparam logic [7:0] OP_LED_ON  = 8'h03;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  // Program images are packed byte vectors; word i lives in bits [8*i +: 8].
  localparam int MAX_DEPTH = 256;
  typedef logic [8*MAX_DEPTH-1:0] image_t;

  localparam image_t DEFAULT_PROGRAM =
    image_t'({OP_HALT, OP_LED_ON, OP_NOP1, OP_LED_OFF, OP_NOP});

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_rom.sv
// DEPTH x 8 instruction ROM with a registered, read-enabled output.
// Also flags combinationally whether the addressed word is the HALT opcode.
module fetch_rom
  import stack_cpu_pkg::*;
#(
  parameter int     ADDR_W  = 4,
  parameter int     DEPTH   = 16,
  parameter image_t PROGRAM = DEFAULT_PROGRAM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              word_is_halt
);

  logic [7:0] mem [DEPTH];
  logic [7:0] word;

  for (genvar i = 0; i < DEPTH; i++) begin : g_image
    assign mem[i] = PROGRAM[8*i +: 8];
  end

  assign word         = mem[addr];
  assign word_is_halt = (word == OP_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= word;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: tick prescaler, program counter and ROM fetch,
// presenting each instruction byte to execute over valid/ready.
module fetch_unit
  import stack_cpu_pkg::*;
#(
  parameter int     CLK_DIV_BITS = 22,
  parameter int     ADDR_W       = 4,
  parameter int     DEPTH        = 16,
  parameter image_t PROGRAM      = DEFAULT_PROGRAM
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  logic [CLK_DIV_BITS-1:0] div_cnt;
  logic                    tick;
  fetch_state_e            state;
  logic                    rom_en;
  logic                    rom_is_halt;
  logic [ADDR_W-1:0]       jump_tgt;
  logic [ADDR_W-1:0]       pc_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CLK_DIV_BITS'(1);
    end
  end

  assign tick     = &div_cnt;
  assign jump_tgt = ADDR_W'(32'(jump_addr) % 32'(DEPTH));
  assign pc_next  = (pc == ADDR_W'(DEPTH - 1)) ? '0 : pc + ADDR_W'(1);
  // A jump landing in FETCH discards the read, so the instr register keeps its value.
  assign rom_en   = (state == S_FETCH) && !jump_valid;

  fetch_rom #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PROGRAM(PROGRAM)
  ) u_rom (
    .clk         (CLK),
    .rst         (RST),
    .en          (rom_en),
    .addr        (pc),
    .data        (instr),
    .word_is_halt(rom_is_halt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (jump_valid && state != S_HALT) begin
      pc          <= jump_tgt;
      instr_valid <= 1'b0;
      state       <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick && run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (rom_is_halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            instr_valid <= 1'b1;
            state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc_next;
            state       <= S_IDLE;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the free-running program,
// then hand-written sequences for backpressure, jump, reset, run and wrap cases.
module tb_fetch_unit;
  import stack_cpu_pkg::*;

  function automatic image_t wrap_image();
    image_t img = '0;
    for (int i = 0; i < 16; i++) img[8*i +: 8] = 8'h10 + 8'(i);
    return img;
  endfunction

  localparam image_t WRAP_IMG = wrap_image();

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       run = 1'b0, jump_valid = 1'b0, instr_ready = 1'b0;
  logic [3:0] jump_addr = '0;
  logic [7:0] instr;
  logic       instr_valid, halted;
  logic [3:0] pc;

  logic       run_w = 1'b0, jv_w = 1'b0, ready_w = 1'b0;
  logic [4:0] ja_w = '0;
  logic [7:0] instr_w;
  logic       valid_w, halted_w;
  logic [4:0] pc_w;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(
    .CLK_DIV_BITS(3),
    .ADDR_W      (4),
    .DEPTH       (16),
    .PROGRAM     (DEFAULT_PROGRAM)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .run        (run),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc         (pc),
    .halted     (halted)
  );

  fetch_unit #(
    .CLK_DIV_BITS(3),
    .ADDR_W      (5),
    .DEPTH       (16),
    .PROGRAM     (WRAP_IMG)
  ) dut_wrap (
    .CLK        (CLK),
    .RST        (RST),
    .run        (run_w),
    .jump_valid (jv_w),
    .jump_addr  (ja_w),
    .instr      (instr_w),
    .instr_valid(valid_w),
    .instr_ready(ready_w),
    .pc         (pc_w),
    .halted     (halted_w)
  );

  typedef struct {
    logic       run;
    logic       ready;
    logic       jv;
    logic [3:0] ja;
    int         n;
    logic [7:0] e_instr;
    logic       e_valid;
    logic [3:0] e_pc;
    logic       e_halted;
  } vec_t;

  vec_t vecs [12];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] ei, input logic ev,
                       input logic [3:0] epc, input logic eh);
    checks++;
    if (instr !== ei || instr_valid !== ev || pc !== epc || halted !== eh) begin
      errors++;
      $display("FAIL %s: got instr=%h valid=%b pc=%0d halted=%b, expected instr=%h valid=%b pc=%0d halted=%b",
               name, instr, instr_valid, pc, halted, ei, ev, epc, eh);
    end
  endtask

  task automatic check_w(input string name, input logic [7:0] ei, input logic ev,
                         input logic [4:0] epc, input logic eh);
    checks++;
    if (instr_w !== ei || valid_w !== ev || pc_w !== epc || halted_w !== eh) begin
      errors++;
      $display("FAIL %s: got instr=%h valid=%b pc=%0d halted=%b, expected instr=%h valid=%b pc=%0d halted=%b",
               name, instr_w, valid_w, pc_w, halted_w, ei, ev, epc, eh);
    end
  endtask

  // Asserts RST between edges, checks outputs while held, releases on the next
  // falling edge so the following rising edge is the first counted edge.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("async_reset", 8'h00, 1'b0, 4'd0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    // Tick edges land at e8, e16, e24, ... after release; valid follows one edge later.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0,  9, 8'h00, 1'b1, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 8'h00, 1'b0, 4'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd0,  7, 8'h02, 1'b1, 4'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 8'h02, 1'b0, 4'd2, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  7, 8'h01, 1'b1, 4'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 8'h01, 1'b0, 4'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  7, 8'h03, 1'b1, 4'd3, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 8'h03, 1'b0, 4'd4, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  6, 8'h03, 1'b0, 4'd4, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 8'hFF, 1'b0, 4'd4, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd2,  1, 8'hFF, 1'b0, 4'd4, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd0, 16, 8'hFF, 1'b0, 4'd4, 1'b1};

    step(2);
    run = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run         = vecs[i].run;
      instr_ready = vecs[i].ready;
      jump_valid  = vecs[i].jv;
      jump_addr   = vecs[i].ja;
      step(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_halted);
    end
    jump_valid = 1'b0;

    // Backpressure: two ticks during the stall are dropped.
    run = 1'b1;
    instr_ready = 1'b0;
    do_reset();
    step(9);
    check("bp_first_valid", 8'h00, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("bp_hold", 8'h00, 1'b1, 4'd0, 1'b0);
    end
    instr_ready = 1'b1;
    step(1);
    check("bp_accept", 8'h00, 1'b0, 4'd1, 1'b0);
    step(1);
    check("bp_idle", 8'h00, 1'b0, 4'd1, 1'b0);
    step(1);
    check("bp_fetch", 8'h00, 1'b0, 4'd1, 1'b0);
    step(1);
    check("bp_next_valid", 8'h02, 1'b1, 4'd1, 1'b0);

    // Jump coinciding with a handshake wins and does not advance pc.
    instr_ready = 1'b0;
    do_reset();
    step(9);
    check("jmp_present", 8'h00, 1'b1, 4'd0, 1'b0);
    instr_ready = 1'b1;
    jump_valid  = 1'b1;
    jump_addr   = 4'd3;
    step(1);
    check("jmp_priority", 8'h00, 1'b0, 4'd3, 1'b0);
    jump_valid = 1'b0;
    step(7);
    check("jmp_target_instr", 8'h03, 1'b1, 4'd3, 1'b0);
    step(1);
    check("jmp_accept", 8'h03, 1'b0, 4'd4, 1'b0);

    // Asynchronous reset in the middle of PRESENT.
    instr_ready = 1'b1;
    do_reset();
    step(10);
    instr_ready = 1'b0;
    step(7);
    check("rst_pre", 8'h02, 1'b1, 4'd1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async", 8'h00, 1'b0, 4'd0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    instr_ready = 1'b1;
    step(8);
    check("rst_tick_edge", 8'h00, 1'b0, 4'd0, 1'b0);
    step(1);
    check("rst_first_valid", 8'h00, 1'b1, 4'd0, 1'b0);

    // run low across three ticks.
    run = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    step(10);
    check("run_pc1", 8'h00, 1'b0, 4'd1, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      check("run_low_idle", 8'h00, 1'b0, 4'd1, 1'b0);
    end
    run = 1'b1;
    step(6);
    check("run_resume_fetch", 8'h00, 1'b0, 4'd1, 1'b0);
    step(1);
    check("run_resume_valid", 8'h02, 1'b1, 4'd1, 1'b0);

    // Wrap instance: 5-bit pc over 16 words, no HALT in the image.
    run = 1'b0;
    do_reset();
    check_w("w_reset", 8'h00, 1'b0, 5'd0, 1'b0);
    run_w   = 1'b1;
    ready_w = 1'b1;
    jv_w    = 1'b1;
    ja_w    = 5'd31;
    step(1);
    check_w("w_jump_mod", 8'h00, 1'b0, 5'd15, 1'b0);
    jv_w = 1'b0;
    step(8);
    check_w("w_last_word", 8'h1F, 1'b1, 5'd15, 1'b0);
    step(1);
    check_w("w_wrap_pc", 8'h1F, 1'b0, 5'd0, 1'b0);
    step(7);
    check_w("w_wrap_instr", 8'h10, 1'b1, 5'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the stack processor. It sits directly upstream of the execute stage that drives the LED. It paces execution with a free-running tick prescaler and holds a program counter over a small instruction ROM. Each fetched byte is presented to execute over a valid/ready handshake. The current program counter is exported for the seven-segment display.

## Interface
Parameters:
- CLK_DIV_BITS, 22, prescaler width; one tick every 2^CLK_DIV_BITS clocks (about 0.26 s at 16 MHz); minimum 1.
- ADDR_W, 4, program counter width.
- DEPTH, 16, ROM words; DEPTH ≤ 2^ADDR_W.

Ports:
- CLK  in  1  system clock (16 MHz).
- RST  in  1  asynchronous, active-high reset.
- run  in  1  fetch enable; ticks are ignored while low.
- jump_valid  in  1  one-cycle redirect request from execute.
- jump_addr  in  ADDR_W  redirect target.
- instr  out  8  instruction byte presented to execute.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  execute accepts instr.
- pc  out  ADDR_W  address of the instruction being fetched or presented; drives the display digit.
- halted  out  1  HALT opcode reached.

## Operation
- Prescaler:
  - CLK_DIV_BITS counter, free-running from reset.
  - tick = (counter == all ones), combinational.
  - The counter is never cleared by jump, run or state changes.
- FSM states:
  - IDLE: on tick && run, go to FETCH. Otherwise stay.
  - FETCH: register instr <= rom[pc].
    - If that byte is HALT (8'hFF): go to HALT and set halted=1. instr_valid stays 0.
    - Otherwise: set instr_valid=1 and go to PRESENT.
  - PRESENT: hold instr and instr_valid stable until instr_valid && instr_ready. On that edge:
    - clear instr_valid;
    - pc <= (pc == DEPTH-1) ? 0 : pc+1;
    - go to IDLE.
  - HALT: absorbing; only RST exits. jump_valid, run and ticks are all ignored.
- Jump (any state except HALT):
  - pc <= jump_addr (values ≥ DEPTH wrap modulo DEPTH).
  - instr_valid <= 0; any pending instruction is discarded.
  - State <= IDLE.
  - Jump has priority over a simultaneous handshake or tick. The discarded instruction does not advance pc.
- Ticks arriving outside IDLE are dropped, not queued.
- Once fetched, run low does not withdraw a presented instruction.
- Reset values: pc=0, instr=8'h00, instr_valid=0, halted=0, state IDLE, counter 0.
- Reset mid-handshake: all outputs return to reset values immediately, asynchronously.

## Timing
- Edge E0 samples tick && run in IDLE.
- E1 (FETCH) registers instr; instr_valid is high after E1. Tick-to-valid latency is 2 edges.
- With instr_ready held high, acceptance happens at E2. pc increments after E2.
- Maximum throughput is one instruction per tick period. This requires the handshake to complete within 2^CLK_DIV_BITS − 2 cycles of valid.
- pc changes only on accept, jump or reset. It is stable throughout PRESENT.
- ROM read is synchronous: one cycle, in FETCH.
- All outputs are registered. No combinational path exists from instr_ready or jump_valid to any output.

## Structure
- Shared package stack_cpu_pkg holds:
  - opcode constants: OP_NOP=8'h00, OP_NOP1=8'h01, OP_LED_OFF=8'h02, OP_LED_ON=8'h03, OP_HALT=8'hFF;
  - the default program image;
  - the FSM state encoding (2 bits).
- Sub-module fetch_rom: DEPTH×8 synchronous-read ROM, initialised from the package program image. Addressed by pc; read enabled in FETCH.

## Test plan
Bench uses CLK_DIV_BITS=3 (tick every 8 clocks) and ROM = {00,02,01,03,FF, rest 00}.
- Reset then run=1, instr_ready=1:
  - instr_valid pulses 2 clocks after each tick, carrying 00,02,01,03 in order;
  - pc reads 0,1,2,3;
  - after the 5th tick, halted=1 and instr_valid never rises again.
- Backpressure: instr_ready=0 for 20 clocks after the first valid.
  - instr=00 and pc=0 stay stable throughout; the 2 intervening ticks are dropped.
  - Raising ready accepts once; the next valid (02) follows 2 clocks after the next tick.
- Jump in PRESENT, same cycle as a handshake, jump_addr=3:
  - instr_valid clears; pc=3;
  - the next presented instr=03.
- Wrap: ROM without HALT, DEPTH=16. After accepting at pc=15, pc=0 and the next instr=rom[0].
- RST asserted mid-PRESENT and asynchronously, between clock edges:
  - instr_valid=0, pc=0, halted=0 immediately;
  - after release, the first valid follows the first tick by 2 clocks.
- run=0 over 3 ticks: no fetch and pc unchanged. A jump while halted leaves pc and halted unchanged.
